// File: rtl/lcd_scanout.sv
`default_nettype none
// lcd_scanout: fetches the 96x64 1bpp LCD framebuffer one row at a time into a
// double line buffer and streams H_SCALE x V_SCALE scaled RGB332 pixels. Rev 1.0
module lcd_scanout #(
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] FB_BASE      = 24'h001000,
  parameter int                H_SCALE      = 4,
  parameter int                V_SCALE      = 4,
  parameter logic [7:0]        ON_COLOR     = 8'h00,
  parameter logic [7:0]        OFF_COLOR    = 8'hFF,
  parameter logic [7:0]        BORDER_COLOR = 8'h49
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_req,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              busy,
  output logic              err_overrun
);

  localparam int         VSH    = $clog2(V_SCALE);
  localparam logic [2:0] H_LAST = 3'(H_SCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          line_q, line_d;
  logic [6:0]          x_q, x_d;
  logic [6:0]          cap_x_q, cap_x_d;
  logic                cap_valid_q, cap_valid_d;
  logic [2:0]          bitsel_q, bitsel_d;
  logic [95:0]         front_q, front_d, back_q, back_d;
  logic                front_valid_q, front_valid_d;
  logic                back_valid_q, back_valid_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [2:0]          sub_q, sub_d;
  logic [6:0]          px_q, px_d;
  logic [7:0]          pixel_q, pixel_d;
  logic                pixel_valid_q, pixel_valid_d;

  logic                trig;
  logic [9:0]          l_next;
  logic [9:0]          row_full;
  logic [5:0]          row;

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    x_d           = x_q;
    cap_x_d       = cap_x_q;
    cap_valid_d   = 1'b0;
    bitsel_d      = bitsel_q;
    front_d       = front_q;
    back_d        = back_q;
    front_valid_d = front_valid_q;
    back_valid_d  = back_valid_q;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    busy_d        = busy_q;
    err_d         = err_q;
    sub_d         = sub_q;
    px_d          = px_q;
    pixel_d       = pixel_q;
    pixel_valid_d = pix_req;

    trig     = frame_start | line_start;
    l_next   = (line_q == 10'd1023) ? line_q : line_q + 10'd1;
    row_full = frame_start ? 10'd0 : (l_next >> VSH);
    row      = row_full[5:0];

    // Read data lands one cycle after its strobe; a new trigger discards it.
    if (cap_valid_q && !trig) begin
      back_d[cap_x_q] = mem_data[bitsel_q];
    end

    case (state_q)
      FETCH: begin
        cap_valid_d = 1'b1;
        cap_x_d     = x_q;
        if (x_q == 7'd95) begin
          state_d  = DRAIN;
          mem_rd_d = 1'b0;
        end else begin
          x_d        = x_q + 7'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        back_valid_d = 1'b1;
      end
      default: ;
    endcase

    if (frame_start) begin
      line_d        = 10'd0;
      err_d         = 1'b0;
      front_valid_d = 1'b0;
    end else if (line_start) begin
      front_d       = back_q;
      front_valid_d = back_valid_q;
      line_d        = l_next;
      if (busy_q) err_d = 1'b1;
    end

    if (trig) begin
      back_valid_d = 1'b0;
      cap_valid_d  = 1'b0;
      x_d          = 7'd0;
      if (row_full < 10'd64) begin
        state_d    = FETCH;
        busy_d     = 1'b1;
        mem_rd_d   = 1'b1;
        mem_addr_d = FB_BASE + (ADDR_W'(row[5:3]) * ADDR_W'(96));
        bitsel_d   = row[2:0];
      end else begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        mem_rd_d = 1'b0;
      end
    end

    if (pix_req) begin
      if (!front_valid_q || (px_q >= 7'd96)) begin
        pixel_d = BORDER_COLOR;
      end else if (front_q[px_q]) begin
        pixel_d = ON_COLOR;
      end else begin
        pixel_d = OFF_COLOR;
      end
      if (sub_q == H_LAST) begin
        sub_d = 3'd0;
        if (px_q != 7'd96) px_d = px_q + 7'd1;
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end

    if (trig) begin
      sub_d = 3'd0;
      px_d  = 7'd0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q       <= IDLE;
      line_q        <= 10'd0;
      x_q           <= 7'd0;
      cap_x_q       <= 7'd0;
      cap_valid_q   <= 1'b0;
      bitsel_q      <= 3'd0;
      front_q       <= '0;
      back_q        <= '0;
      front_valid_q <= 1'b0;
      back_valid_q  <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      sub_q         <= 3'd0;
      px_q          <= 7'd0;
      pixel_q       <= BORDER_COLOR;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      x_q           <= x_d;
      cap_x_q       <= cap_x_d;
      cap_valid_q   <= cap_valid_d;
      bitsel_q      <= bitsel_d;
      front_q       <= front_d;
      back_q        <= back_d;
      front_valid_q <= front_valid_d;
      back_valid_q  <= back_valid_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      sub_q         <= sub_d;
      px_q          <= px_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign busy        = busy_q;
  assign err_overrun = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_scanout.sv
`default_nettype none
// tb_lcd_scanout: randomized scenarios checked against a frame-level model of
// the scan-out (which row sits in which buffer, when each fetch finishes).
module tb_lcd_scanout;

  localparam int         FB   = 'h1000;
  localparam int         HS   = 4;
  localparam int         VS   = 4;
  localparam logic [7:0] ONC  = 8'h00;
  localparam logic [7:0] OFFC = 8'hFF;
  localparam logic [7:0] BRD  = 8'h49;

  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pix_req = 1'b0;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        busy;
  logic        err_overrun;

  lcd_scanout #(
    .ADDR_W(24), .FB_BASE(24'h001000), .H_SCALE(HS), .V_SCALE(VS),
    .ON_COLOR(ONC), .OFF_COLOR(OFFC), .BORDER_COLOR(BRD)
  ) dut (
    .pclk(pclk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .pix_req(pix_req), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 pclk = ~pclk;

  logic [7:0] ram [0:8191];

  // Memory answers one cycle after the strobe; junk otherwise.
  always @(posedge pclk) begin
    if (mem_rd) mem_data <= ram[mem_addr[12:0]];
    else        mem_data <= 8'($urandom);
  end

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;

  // Model: L counter, row being fetched (-1 none), trigger edge, displayed row.
  int         m_L, m_fetch_row, m_trig, m_front_row, m_k;
  logic       m_err;
  logic [7:0] m_last;

  int          g_rd_count, g_on, g_on_first, g_border, g_reqs;
  logic [23:0] g_first_addr;

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_L = 0; m_fetch_row = -1; m_trig = -1000; m_front_row = -1;
    m_k = 0; m_err = 1'b0; m_last = BRD;
  endtask

  task automatic model_trigger(input bit fs, input bit ls);
    int  new_row;
    bit  busy_prev;
    busy_prev = (m_fetch_row >= 0) && ((cyc - 1 - m_trig) <= 96);
    new_row = -1;
    if (fs) begin
      m_L = 0; m_err = 1'b0; m_front_row = -1; new_row = 0;
    end else if (ls) begin
      if (busy_prev) m_err = 1'b1;
      m_front_row = busy_prev ? -1 : m_fetch_row;
      m_L = (m_L >= 1023) ? 1023 : m_L + 1;
      new_row = m_L / VS;
      if (new_row >= 64) new_row = -1;
    end
    m_fetch_row = new_row;
    m_trig = cyc;
    m_k = 0;
  endtask

  function automatic logic exp_rd();
    return (m_fetch_row >= 0) && ((cyc - m_trig) <= 95);
  endfunction

  function automatic logic exp_busy();
    return (m_fetch_row >= 0) && ((cyc - m_trig) <= 96);
  endfunction

  function automatic logic [23:0] exp_addr();
    return 24'(FB + (m_fetch_row / 8) * 96 + (cyc - m_trig));
  endfunction

  function automatic logic [7:0] exp_pixel(input int k);
    int         col;
    logic [7:0] b;
    col = k / HS;
    if (m_front_row < 0 || col >= 96) return BRD;
    b = ram[FB + (m_front_row / 8) * 96 + col];
    return b[m_front_row % 8] ? ONC : OFFC;
  endfunction

  // One line: trigger pulse, then 'cycles' cycles checking fetch and pixels.
  task automatic drive_line(input bit fs, input bit ls, input int cycles, input bit full);
    logic [7:0] e;
    logic       r;
    frame_start = fs; line_start = ls; pix_req = 1'b0;
    step();
    frame_start = 1'b0; line_start = 1'b0;
    model_trigger(fs, ls);
    g_first_addr = mem_addr; g_rd_count = 0; g_on = 0; g_on_first = -1;
    g_border = 0; g_reqs = 0;
    tests_run++;
    if (err_overrun !== m_err) begin
      failed++;
      $display("FAIL err_overrun after trigger L=%0d: got %b expected %b", m_L, err_overrun, m_err);
    end
    for (int i = 0; i < cycles; i++) begin
      tests_run++;
      if (mem_rd !== exp_rd() || busy !== exp_busy() || (exp_rd() && mem_addr !== exp_addr())) begin
        failed++;
        $display("FAIL fetch L=%0d off=%0d: mem_rd=%b busy=%b addr=%h, expected mem_rd=%b busy=%b addr=%h",
                 m_L, cyc - m_trig, mem_rd, busy, mem_addr, exp_rd(), exp_busy(), exp_addr());
      end
      if (mem_rd === 1'b1) g_rd_count++;
      r = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      pix_req = r;
      step();
      if (r) begin
        e = exp_pixel(m_k);
        if (e == ONC) begin
          g_on++;
          if (g_on_first < 0) g_on_first = m_k;
        end
        if (e == BRD) g_border++;
        m_k++; g_reqs++; m_last = e;
      end else begin
        e = m_last;
      end
      tests_run++;
      if (pixel_valid !== r || pixel !== e) begin
        failed++;
        $display("FAIL pixel L=%0d req#%0d: valid=%b pixel=%h, expected valid=%b pixel=%h",
                 m_L, m_k, pixel_valid, pixel, r, e);
      end
    end
    pix_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step(); reset = 1'b1;
    model_reset();
    drive_line(1'b1, 1'b0, 10, 1'b0);
    drive_line(1'b0, 1'b1, 5, 1'b0);
    tests_run++;
    if (mem_rd !== 1'b1 || err_overrun !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset_fetch: mem_rd=%b err=%b, expected 1 1", mem_rd, err_overrun);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || pixel !== 8'h49 || err_overrun !== 1'b0
        || pixel_valid !== 1'b0 || mem_addr !== 24'h0) begin
      failed++;
      $display("FAIL reset_state: mem_rd=%b busy=%b pixel=%h err=%b valid=%b addr=%h, expected 0 0 49 0 0 000000",
               mem_rd, busy, pixel, err_overrun, pixel_valid, mem_addr);
    end
    step(); step();
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (mem_rd !== 1'b0 || busy !== 1'b0 || pixel !== BRD) begin
        failed++;
        $display("FAIL post_reset_idle: mem_rd=%b busy=%b pixel=%h, expected 0 0 49", mem_rd, busy, pixel);
      end
    end
  endtask

  task automatic test_frame_fetch();
    drive_line(1'b1, 1'b0, 110, 1'b0);
    tests_run++;
    if (g_first_addr !== 24'h001000 || g_rd_count !== 96) begin
      failed++;
      $display("FAIL frame_fetch: first_addr=%h reads=%0d, expected 001000 96", g_first_addr, g_rd_count);
    end
    drive_line(1'b0, 1'b1, 400, 1'b1);
    tests_run++;
    if (g_reqs !== 400 || g_border !== 16) begin
      failed++;
      $display("FAIL row0_display: reqs=%0d border=%0d, expected 400 16", g_reqs, g_border);
    end
  endtask

  task automatic test_row_lines();
    while (m_L < 12) drive_line(1'b0, 1'b1, (m_L >= 10) ? 400 : 100, (m_L >= 10));
    tests_run++;
    if (g_on !== 4 || g_on_first !== 20) begin
      failed++;
      $display("FAIL row2_byte5: on_count=%0d first_on_req=%0d, expected 4 20", g_on, g_on_first);
    end
  endtask

  task automatic test_last_rows();
    while (m_L < 254) drive_line(1'b0, 1'b1, 100, 1'b0);
    drive_line(1'b0, 1'b1, 100, 1'b0);
    tests_run++;
    if (g_first_addr !== 24'h0012A0 || g_rd_count !== 96) begin
      failed++;
      $display("FAIL row63_fetch: first_addr=%h reads=%0d, expected 0012a0 96", g_first_addr, g_rd_count);
    end
    drive_line(1'b0, 1'b1, 100, 1'b1);
    tests_run++;
    if (g_rd_count !== 0) begin
      failed++;
      $display("FAIL row64_no_fetch: reads=%0d, expected 0", g_rd_count);
    end
    drive_line(1'b0, 1'b1, 120, 1'b1);
    tests_run++;
    if (g_border !== 120 || g_reqs !== 120) begin
      failed++;
      $display("FAIL past_image_border: border=%0d reqs=%0d, expected 120 120", g_border, g_reqs);
    end
  endtask

  task automatic test_simultaneous();
    drive_line(1'b1, 1'b1, 110, 1'b0);
    tests_run++;
    if (g_first_addr !== 24'h001000 || g_rd_count !== 96) begin
      failed++;
      $display("FAIL simul_fetch: first_addr=%h reads=%0d, expected 001000 96", g_first_addr, g_rd_count);
    end
    drive_line(1'b0, 1'b1, 110, 1'b0);
    tests_run++;
    if (g_first_addr !== 24'h001000 || g_rd_count !== 96) begin
      failed++;
      $display("FAIL simul_line_reset: first_addr=%h reads=%0d, expected 001000 96", g_first_addr, g_rd_count);
    end
    drive_line(1'b1, 1'b1, 110, 1'b1);
    tests_run++;
    if (g_border !== g_reqs || g_reqs !== 110) begin
      failed++;
      $display("FAIL simul_no_swap: border=%0d reqs=%0d, expected 110 110", g_border, g_reqs);
    end
  endtask

  task automatic test_overrun();
    drive_line(1'b1, 1'b0, 120, 1'b0);
    drive_line(1'b0, 1'b1, 50, 1'b0);
    drive_line(1'b0, 1'b1, 120, 1'b1);
    tests_run++;
    if (err_overrun !== 1'b1 || g_first_addr !== 24'h001000 || g_border !== 120) begin
      failed++;
      $display("FAIL overrun: err=%b first_addr=%h border=%0d, expected 1 001000 120",
               err_overrun, g_first_addr, g_border);
    end
    drive_line(1'b0, 1'b1, 100, 1'b1);
    drive_line(1'b1, 1'b0, 20, 1'b0);
    tests_run++;
    if (err_overrun !== 1'b0) begin
      failed++;
      $display("FAIL overrun_clear: err=%b, expected 0", err_overrun);
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) ram[a] = 8'($urandom);
    for (int x = 0; x < 96; x++) ram[FB + x][2] = (x == 5);
    model_reset();
    test_reset();
    test_frame_fetch();
    test_row_lines();
    test_last_rows();
    test_simultaneous();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Scan-out stage upstream of the VGA pixel output.
- Fetches the 96x64 1bpp LCD framebuffer from system RAM one source row at a time into a double-buffered line buffer.
- Emits one RGB332 pixel per request, scaled H_SCALE x V_SCALE, with border colour outside the image.
- Fetching runs one VGA line ahead of display.

Parameters:
- ADDR_W, 24, memory address width.
- FB_BASE, 24'h001000, byte address of framebuffer page 0, column 0.
- H_SCALE, 4, VGA pixels per source pixel (power of two, 1..8).
- V_SCALE, 4, VGA lines per source row (power of two, 1..8).
- ON_COLOR, 8'h00, RGB332 value for a set bit.
- OFF_COLOR, 8'hFF, RGB332 value for a clear bit.
- BORDER_COLOR, 8'h49, RGB332 value outside the image.

Ports:
- pclk, input, 1, pixel/system clock.
- reset, input, 1, synchronous, active-low reset.
- frame_start, input, 1, one-cycle pulse at start of frame (before first visible line).
- line_start, input, 1, one-cycle pulse at start of each VGA line's horizontal blank.
- pix_req, input, 1, display consumes one pixel this cycle.
- mem_rd, output, 1, read strobe.
- mem_addr, output, ADDR_W, read byte address.
- mem_data, input, 8, read data, valid exactly 1 cycle after mem_rd.
- pixel, output, 8, RGB332 pixel.
- pixel_valid, output, 1, pixel corresponds to previous-cycle pix_req.
- busy, output, 1, fetch in progress.
- err_overrun, output, 1, sticky: line_start arrived during a fetch.

Behaviour:
- Reset (reset==0 at pclk edge):
  - FSM=IDLE; line counter=0; x counter=0; sub-counters=0.
  - Both line buffers invalid.
  - mem_rd=0, mem_addr=0, pixel=BORDER_COLOR, pixel_valid=0, busy=0, err_overrun=0.
  - Reset mid-fetch abandons the fetch; no further mem_rd.
- Line buffers: front (displayed) and back (filling), 96 bits each, plus a valid flag per buffer.
- Addressing for source row r, column x:
  - mem_addr = FB_BASE + (r>>3)*96 + x.
  - Pixel = mem_data[r[2:0]] (LSB is top row of page).
  - Arithmetic in ADDR_W bits, wraps modulo 2^ADDR_W.
- frame_start:
  - Line counter L=0; err_overrun cleared; front invalidated.
  - Starts fetch of source row 0 into back.
- line_start:
  - Front<=back (including valid flag).
  - L increments (saturating at 1023).
  - Starts fetch for line L+1: source row r=(L+1)/V_SCALE.
  - If r>=64: no memory reads; back marked invalid; FSM stays IDLE.
- frame_start and line_start in the same cycle: frame_start wins; no swap.
- FSM states:
  - IDLE: busy=0.
  - FETCH:
    - mem_rd=1 for 96 consecutive cycles, x=0..95.
    - Data for x captured into back[x] the following cycle.
    - Entered the cycle after the trigger.
  - DRAIN: one cycle capturing byte 95; then back valid=1, go to IDLE.
  - busy=1 in FETCH and DRAIN; a full fetch is 97 cycles from the trigger cycle's next edge.
- Overrun:
  - line_start while busy: err_overrun<=1; current fetch aborted.
  - Swap still occurs, but the incomplete back is invalid.
  - New fetch restarts from x=0.
- Pixel output:
  - line_start and frame_start reset the horizontal position (sub-counter and source x) to 0.
  - Each pix_req cycle: next cycle pixel_valid=1 and pixel is one of:
    - front invalid or source x>=96: BORDER_COLOR.
    - front[x]==1: ON_COLOR.
    - front[x]==0: OFF_COLOR.
  - Source x advances every H_SCALE requests and saturates at 96.
  - No pix_req: pixel_valid=0 and pixel holds its value.

Test Plan:
- Reset held 3 cycles with mem_rd forced by a prior fetch -> cycle after reset edge: mem_rd=0, busy=0, pixel=8'h49, err_overrun=0.
- frame_start, RAM[0x1000+x]=x -> mem_addr 0x1000..0x105F on 96 consecutive cycles; busy falls 97 cycles after pulse; back[x]=x[0].
- Line with L=10 (rows 11/4=2), RAM page0 byte 5=8'h04 -> after swap, pix_req #20..23 (x=5) give 8'h00; other x give 8'hFF; requests 384+ give 8'h49.
- line_start for L=254 (row 255/4=63) -> mem_addr starts 0x1000+7*96=0x12A0, bit 7 used. line_start at L=255 -> no mem_rd; the following line displays all 8'h49.
- line_start 50 cycles into a fetch -> err_overrun=1; mem_addr restarts at x=0; the next line outputs border; the next frame_start clears err_overrun.
- frame_start and line_start in the same cycle -> L=0, no swap, fetch of row 0 begins next cycle.
